// File: rtl/ecc_operand_loader_if.sv
// ecc_operand_loader_if: digit-beat input stream, operand-set output stream and error pulses
interface ecc_operand_loader_if #(
  parameter int DIGIT_W = 4,
  parameter int WORD_W  = 32,
  parameter int NUM_CH  = 5
);
  logic                      in_valid;
  logic                      in_start;
  logic [NUM_CH*DIGIT_W-1:0] in_digit;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_CH*WORD_W-1:0]  out_word;
  logic                      err_orphan;
  logic                      err_restart;
  modport slave (
    input  in_valid, in_start, in_digit, out_ready,
    output in_ready, out_valid, out_word, err_orphan, err_restart
  );
  modport master (
    output in_valid, in_start, in_digit, out_ready,
    input  in_ready, out_valid, out_word, err_orphan, err_restart
  );
endinterface

// File: rtl/ecc_operand_loader.sv
// ecc_operand_loader: deserializes NUM_CH digit-serial operands into full words with valid/ready output
module ecc_operand_loader #(
  parameter int DIGIT_W   = 4,
  parameter int WORD_W    = 32,
  parameter int NUM_CH    = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  ecc_operand_loader_if.slave bus
);
  localparam int BEATS = WORD_W / DIGIT_W;
  localparam int CW    = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NUM_CH*WORD_W-1:0] word_q, word_d, load_w, shift_w;
  logic                     in_ready_q, out_valid_q;
  logic                     err_orphan_q, err_orphan_d, err_restart_q, err_restart_d;
  logic                     acc, last;
  // first digit lands where successive shifts will carry it to its final position
  always_comb begin
    load_w  = '0;
    shift_w = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      load_w[c*WORD_W +: WORD_W] = MSB_FIRST
        ? {{(WORD_W-DIGIT_W){1'b0}}, bus.in_digit[c*DIGIT_W +: DIGIT_W]}
        : {bus.in_digit[c*DIGIT_W +: DIGIT_W], {(WORD_W-DIGIT_W){1'b0}}};
      shift_w[c*WORD_W +: WORD_W] = MSB_FIRST
        ? {word_q[c*WORD_W +: WORD_W-DIGIT_W], bus.in_digit[c*DIGIT_W +: DIGIT_W]}
        : {bus.in_digit[c*DIGIT_W +: DIGIT_W], word_q[c*WORD_W+DIGIT_W +: WORD_W-DIGIT_W]};
    end
  end
  always_comb begin
    acc           = bus.in_valid && in_ready_q;
    last          = cnt_q == CW'(BEATS-1);
    state_d       = state_q;
    cnt_d         = cnt_q;
    word_d        = word_q;
    err_orphan_d  = 1'b0;
    err_restart_d = 1'b0;
    if (state_q == HOLD) begin
      if (bus.out_ready) state_d = IDLE;
    end else if (acc && bus.in_start) begin
      word_d        = load_w;
      cnt_d         = CW'(1);
      state_d       = LOAD;
      err_restart_d = state_q == LOAD;
    end else if (acc && state_q == IDLE) begin
      err_orphan_d = 1'b1;
    end else if (acc) begin
      word_d  = shift_w;
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      state_d = last ? HOLD : LOAD;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      word_q        <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      err_orphan_q  <= 1'b0;
      err_restart_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      in_ready_q    <= state_d != HOLD;
      out_valid_q   <= state_d == HOLD;
      err_orphan_q  <= err_orphan_d;
      err_restart_q <= err_restart_d;
    end
  end
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_word    = word_q;
  assign bus.err_orphan  = err_orphan_q;
  assign bus.err_restart = err_restart_q;
endmodule

// File: tb/tb_ecc_operand_loader.sv
// tb_ecc_operand_loader: MSB-first and LSB-first loaders fed the same stream, checked against a frame-level model
module tb_ecc_operand_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_start = 1'b0, out_ready = 1'b0;
  logic [19:0] in_digit = '0;
  int unsigned total = 0, bad = 0;
  bit          hold = 0;
  int          n = 0;
  logic [3:0]  fr [8][5];
  logic [31:0] em [5];
  logic [31:0] el [5];
  bit          eo = 0, er = 0;
  always #5 clk = ~clk;
  ecc_operand_loader_if i_msb ();
  ecc_operand_loader_if i_lsb ();
  assign i_msb.in_valid  = in_valid;
  assign i_msb.in_start  = in_start;
  assign i_msb.in_digit  = in_digit;
  assign i_msb.out_ready = out_ready;
  assign i_lsb.in_valid  = in_valid;
  assign i_lsb.in_start  = in_start;
  assign i_lsb.in_digit  = in_digit;
  assign i_lsb.out_ready = out_ready;
  ecc_operand_loader #(.MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(i_msb.slave));
  ecc_operand_loader #(.MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(i_lsb.slave));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(input logic v, input logic s, input logic [19:0] d, input logic r);
    eo = 0;
    er = 0;
    if (hold) begin
      if (r) hold = 0;
    end else if (v) begin
      if (s) begin
        er = n > 0;
        n  = 0;
      end else if (n == 0) eo = 1;
      if (s || n > 0) begin
        for (int c = 0; c < 5; c++) fr[n][c] = d[c*4 +: 4];
        n++;
        if (n == 8) begin
          hold = 1;
          n    = 0;
          for (int c = 0; c < 5; c++) begin
            em[c] = '0;
            el[c] = '0;
            for (int i = 0; i < 8; i++) begin
              em[c] |= 32'(fr[i][c]) << (4 * (7 - i));
              el[c] |= 32'(fr[i][c]) << (4 * i);
            end
          end
        end
      end
    end
  endtask
  task automatic check_all();
    chk("rdy_m", i_msb.in_ready, !hold);
    chk("rdy_l", i_lsb.in_ready, !hold);
    chk("vld_m", i_msb.out_valid, hold);
    chk("vld_l", i_lsb.out_valid, hold);
    chk("orph_m", i_msb.err_orphan, eo);
    chk("orph_l", i_lsb.err_orphan, eo);
    chk("rest_m", i_msb.err_restart, er);
    chk("rest_l", i_lsb.err_restart, er);
    if (hold)
      for (int c = 0; c < 5; c++) begin
        chk($sformatf("word_m%0d", c), i_msb.out_word[c*32 +: 32], em[c]);
        chk($sformatf("word_l%0d", c), i_lsb.out_word[c*32 +: 32], el[c]);
      end
  endtask
  task automatic cyc(input logic v, input logic s, input logic [19:0] d, input logic r);
    in_valid  = v;
    in_start  = s;
    in_digit  = d;
    out_ready = r;
    @(posedge clk);
    #1;
    model(v, s, d, r);
    check_all();
  endtask
  task automatic reset_now();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    hold = 0;
    n    = 0;
    eo   = 0;
    er   = 0;
    chk("rst_vld_m", i_msb.out_valid, 1'b0);
    chk("rst_vld_l", i_lsb.out_valid, 1'b0);
    chk("rst_word_m", i_msb.out_word[63:0], 64'h0);
    chk("rst_word_l", i_lsb.out_word[159:96], 64'h0);
    chk("rst_errs", {i_msb.err_orphan, i_msb.err_restart, i_lsb.err_orphan, i_lsb.err_restart}, 4'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask
  function automatic logic [19:0] mk(input logic [3:0] c0, input logic [3:0] c4);
    logic [19:0] d;
    d        = 20'($urandom);
    d[3:0]   = c0;
    d[19:16] = c4;
    return d;
  endfunction
  task automatic frame(input int gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps != 0) repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 20'($urandom), 1'b0);
      cyc(1'b1, i == 0, mk(4'(i + 1), 4'(15 - i)), 1'b0);
    end
  endtask
  initial begin
    #12;
    chk("rst_rdy", i_msb.in_ready, 1'b1);
    chk("rst_vld", i_msb.out_valid, 1'b0);
    chk("rst_word", i_msb.out_word[31:0], 32'h0);
    @(negedge clk);
    rst = 1'b1;
    frame(0);
    chk("tp_ch0_m", i_msb.out_word[31:0], 32'h12345678);
    chk("tp_ch4_m", i_msb.out_word[159:128], 32'hFEDCBA98);
    chk("tp_ch0_l", i_lsb.out_word[31:0], 32'h87654321);
    repeat (10) cyc(1'b1, 1'b1, 20'($urandom), 1'b0);
    cyc(1'b0, 1'b0, 20'h0, 1'b1);
    cyc(1'b0, 1'b0, 20'h0, 1'b1);
    frame(1);
    chk("gap_ch0_l", i_lsb.out_word[31:0], 32'h87654321);
    cyc(1'b0, 1'b0, 20'h0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, i == 0, mk(4'(i + 1), 4'h0), 1'b0);
    cyc(1'b1, 1'b1, 20'hAAAAA, 1'b0);
    repeat (7) cyc(1'b1, 1'b0, 20'hAAAAA, 1'b0);
    chk("resync_m", i_msb.out_word[31:0], 32'hAAAAAAAA);
    chk("resync_l", i_lsb.out_word[31:0], 32'hAAAAAAAA);
    cyc(1'b0, 1'b0, 20'h0, 1'b1);
    repeat (3) begin
      cyc(1'b1, 1'b0, 20'($urandom), 1'b0);
      cyc(1'b0, 1'b0, 20'h0, 1'b1);
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, i == 0, mk(4'(i + 1), 4'h3), 1'b0);
    reset_now();
    frame(0);
    reset_now();
    frame(1);
    chk("post_rst_m", i_msb.out_word[31:0], 32'h12345678);
    cyc(1'b0, 1'b0, 20'h0, 1'b1);
    repeat (400)
      cyc(($urandom % 4) != 0, ($urandom % 10) == 0, 20'($urandom), ($urandom % 3) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
